// File: rtl/pool_pkg.sv
// Shared definitions for the max-pool window sequencer: default sizes, FSM state codes
// and the row-major window sample address helper.
package pool_pkg;

    localparam int DATA_W   = 22;
    localparam int WIN      = 4;
    localparam int WIN_AREA = WIN * WIN;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_POOL  = 3'd2;
    localparam state_t ST_WRITE = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // Address of sample k (row-major inside the window) of window (wx, wy); caller truncates.
    function automatic int unsigned win_sample_addr(
        input int unsigned wx,
        input int unsigned wy,
        input int unsigned k,
        input int unsigned img_w,
        input int unsigned win
    );
        win_sample_addr = (wy * win + k / win) * img_w + wx * win + k % win;
    endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Owns the window (wx, wy) and fetch (k) counters; issues the registered read strobe/address
// and the slot index that the returning read data belongs to.
module window_addr_gen #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int WIN    = 4,
    parameter int ADDR_W = 6,
    parameter int KW     = 5,
    parameter int SW     = 4,
    parameter int XW     = 1,
    parameter int YW     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              k_inc,
    input  logic              win_adv,
    input  logic              fetch_nx,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [KW-1:0]     k,
    output logic [SW-1:0]     slot,
    output logic [XW-1:0]     wx,
    output logic [YW-1:0]     wy,
    output logic              last_win
);
    import pool_pkg::*;

    localparam int AREA = WIN * WIN;
    localparam int NWX  = IMG_W / WIN;
    localparam int NWY  = IMG_H / WIN;

    logic [KW-1:0]     k_r, k_nx_s;
    logic [XW-1:0]     wx_r, wx_nx_s;
    logic [YW-1:0]     wy_r, wy_nx_s;
    logic              rd_en_r, rd_nx_s;
    logic [ADDR_W-1:0] rd_addr_r;

    // Next values of the fetch counter and the raster window position
    always_comb begin
        k_nx_s  = k_r;
        wx_nx_s = wx_r;
        wy_nx_s = wy_r;
        if (clr) begin
            k_nx_s  = KW'(0);
            wx_nx_s = XW'(0);
            wy_nx_s = YW'(0);
        end else if (k_inc) begin
            k_nx_s = k_r + KW'(1);
        end else if (win_adv) begin
            k_nx_s = KW'(0);
            if (wx_r == XW'(NWX - 1)) begin
                wx_nx_s = XW'(0);
                wy_nx_s = wy_r + YW'(1);
            end else begin
                wx_nx_s = wx_r + XW'(1);
                wy_nx_s = wy_r;
            end
        end else begin
            k_nx_s  = k_r;
            wx_nx_s = wx_r;
            wy_nx_s = wy_r;
        end
    end

    assign rd_nx_s = fetch_nx && (k_nx_s < KW'(AREA));

    // Counter state plus read strobe/address registered one cycle ahead of use
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_r       <= KW'(0);
            wx_r      <= XW'(0);
            wy_r      <= YW'(0);
            rd_en_r   <= 1'b0;
            rd_addr_r <= ADDR_W'(0);
        end else begin
            k_r     <= k_nx_s;
            wx_r    <= wx_nx_s;
            wy_r    <= wy_nx_s;
            rd_en_r <= rd_nx_s;
            if (rd_nx_s) begin
                rd_addr_r <= ADDR_W'(win_sample_addr(32'(wx_nx_s), 32'(wy_nx_s), 32'(k_nx_s),
                                                     IMG_W, WIN));
            end
        end
    end

    assign rd_en    = rd_en_r;
    assign rd_addr  = rd_addr_r;
    assign k        = k_r;
    assign slot     = SW'(k_r - KW'(1));
    assign wx       = wx_r;
    assign wy       = wy_r;
    assign last_win = (wx_r == XW'(NWX - 1)) && (wy_r == YW'(NWY - 1));

endmodule

// File: rtl/maxpool_window_sequencer.sv
// Walks the feature map window by window, gathers each window into a register file,
// hands it to the shared pooling unit and writes the pooled value to the output buffer.
module maxpool_window_sequencer #(
    parameter int DATA_W  = pool_pkg::DATA_W,
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int WIN     = pool_pkg::WIN,
    parameter int ADDR_W  = 6,
    parameter int OADDR_W = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_rd_addr,
    input  logic [DATA_W-1:0]         mem_rd_data,
    output logic [WIN*WIN*DATA_W-1:0] win_data,
    output logic                      pool_en,
    input  logic                      pool_done,
    input  logic [DATA_W-1:0]         pool_result,
    output logic                      out_wr_en,
    output logic [OADDR_W-1:0]        out_wr_addr,
    output logic [DATA_W-1:0]         out_wr_data
);
    import pool_pkg::*;

    localparam int AREA = WIN * WIN;
    localparam int KW   = $clog2(AREA + 1);
    localparam int SW   = (AREA > 1) ? $clog2(AREA) : 1;
    localparam int NWX  = IMG_W / WIN;
    localparam int NWY  = IMG_H / WIN;
    localparam int XW   = (NWX > 1) ? $clog2(NWX) : 1;
    localparam int YW   = (NWY > 1) ? $clog2(NWY) : 1;

    state_t             state_r, state_nx_s;
    logic               clr_s, k_inc_s, win_adv_s, fetch_nx_s;
    logic [KW-1:0]      k_s;
    logic [SW-1:0]      slot_s;
    logic [XW-1:0]      wx_s;
    logic [YW-1:0]      wy_s;
    logic               last_win_s;
    logic [DATA_W-1:0]  win_r [AREA];
    logic               busy_r, done_r, pool_en_r, out_wr_en_r;
    logic [OADDR_W-1:0] out_wr_addr_r;
    logic [DATA_W-1:0]  out_wr_data_r;

    window_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .WIN   (WIN),
        .ADDR_W(ADDR_W),
        .KW    (KW),
        .SW    (SW),
        .XW    (XW),
        .YW    (YW)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr_s),
        .k_inc   (k_inc_s),
        .win_adv (win_adv_s),
        .fetch_nx(fetch_nx_s),
        .rd_en   (mem_rd_en),
        .rd_addr (mem_rd_addr),
        .k       (k_s),
        .slot    (slot_s),
        .wx      (wx_s),
        .wy      (wy_s),
        .last_win(last_win_s)
    );

    // FSM next state and counter control strobes
    always_comb begin
        state_nx_s = state_r;
        clr_s      = 1'b0;
        k_inc_s    = 1'b0;
        win_adv_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    clr_s      = 1'b1;
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (k_s == KW'(AREA)) begin
                    state_nx_s = ST_POOL;
                end else begin
                    k_inc_s    = 1'b1;
                    state_nx_s = ST_FETCH;
                end
            end
            ST_POOL: begin
                if (pool_done) begin
                    state_nx_s = ST_WRITE;
                end else begin
                    state_nx_s = ST_POOL;
                end
            end
            ST_WRITE: begin
                win_adv_s = 1'b1;
                if (last_win_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_DONE:  state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    assign fetch_nx_s = (state_nx_s == ST_FETCH);

    // State register; handshake outputs are registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            pool_en_r     <= 1'b0;
            out_wr_en_r   <= 1'b0;
            out_wr_addr_r <= OADDR_W'(0);
            out_wr_data_r <= DATA_W'(0);
        end else begin
            state_r     <= state_nx_s;
            busy_r      <= (state_nx_s != ST_IDLE);
            done_r      <= (state_nx_s == ST_DONE);
            pool_en_r   <= (state_nx_s == ST_POOL);
            out_wr_en_r <= (state_nx_s == ST_WRITE);
            if ((state_r == ST_POOL) && pool_done) begin
                out_wr_data_r <= pool_result;
                out_wr_addr_r <= OADDR_W'(int'(wy_s) * NWX + int'(wx_s));
            end
        end
    end

    // Read data returns one cycle after its strobe, so it lands in the slot one behind k
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < AREA; i++) begin
                win_r[i] <= DATA_W'(0);
            end
        end else if ((state_r == ST_FETCH) && (k_s != KW'(0))) begin
            win_r[slot_s] <= mem_rd_data;
        end
    end

    for (genvar g = 0; g < AREA; g++) begin : g_win_pack
        assign win_data[g*DATA_W +: DATA_W] = win_r[g];
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign pool_en     = pool_en_r;
    assign out_wr_en   = out_wr_en_r;
    assign out_wr_addr = out_wr_addr_r;
    assign out_wr_data = out_wr_data_r;

endmodule

// File: doc/maxpool_window_sequencer.md
# maxpool_window_sequencer

Controller that walks a feature map stored in a single-port read memory, gathers each non-overlapping WIN×WIN window, and drives one shared maxPooling unit through its enable/done handshake. It writes one pooled result per window into an output buffer in raster order. It sits between the feature-map SRAM and the pooling datapath, and is started by the layer-level controller.

## Interface
Parameters:
- DATA_W, 22: sample width, signed two's complement
- IMG_W, 8: feature-map width in samples; multiple of WIN
- IMG_H, 8: feature-map height in samples; multiple of WIN
- WIN, 4: window side and stride; WIN*WIN = 16 matches the pooling unit inputs
- ADDR_W, 6: read address width, ≥ clog2(IMG_W*IMG_H)
- OADDR_W, 2: output address width, ≥ clog2((IMG_W/WIN)*(IMG_H/WIN))

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request to process the whole map; sampled only in IDLE
- busy  out  1  high from the cycle after an accepted start through the DONE state
- done  out  1  one-cycle pulse when the last result is written
- mem_rd_en  out  1  read strobe to the feature-map memory
- mem_rd_addr  out  ADDR_W  row-major sample address
- mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
- win_data  out  16*DATA_W  gathered window; slot k is at bits [k*DATA_W +: DATA_W], k = r*WIN + c
- pool_en  out  1  enable to the pooling unit
- pool_done  in  1  pooling unit completion flag
- pool_result  in  DATA_W  pooled maximum, valid when pool_done = 1
- out_wr_en  out  1  write strobe to the output buffer
- out_wr_addr  out  OADDR_W  window index, wy*(IMG_W/WIN) + wx
- out_wr_data  out  DATA_W  pooled value

## Operation
- States: IDLE, FETCH, POOL, WRITE, DONE.
- IDLE: when start = 1, clear wx, wy and the fetch counter k, then go to FETCH. Otherwise stay in IDLE.
- FETCH has 17 cycles, with k running from 0 to 16.
  - For k ≤ 15: mem_rd_en = 1 and mem_rd_addr = (wy*WIN + k/WIN)*IMG_W + wx*WIN + k%WIN.
  - For k ≥ 1: capture mem_rd_data into slot k−1.
  - After k = 16, go to POOL.
- POOL: hold pool_en = 1 and win_data stable. On the first cycle pool_done = 1, latch pool_result, drop pool_en, and go to WRITE.
- WRITE: one cycle with out_wr_en = 1, carrying the latched value and the window index.
  - Then advance wx. When wx wraps at IMG_W/WIN−1, clear wx and increment wy.
  - If the window just written was the last one, go to DONE. Otherwise go to FETCH with k = 0.
- DONE: assert done for one cycle, then go to IDLE.
- start outside IDLE is ignored. No queueing.
- The sequencer does not interpret data values: no arithmetic on samples, and results are passed through unmodified.
- Address arithmetic is unsigned. All intermediate products are sized to ADDR_W.

## Timing
- Reset values: busy, done, mem_rd_en, pool_en and out_wr_en are 0. mem_rd_addr, out_wr_addr, out_wr_data and win_data are 0. State is IDLE.
- rst_n = 0 in any state: the next cycle shows all reset values. A partially written output buffer is left as is.
- Per-window latency is 17 + L + 1 cycles, where L is the number of cycles from the first pool_en = 1 to the pool_done = 1 sample (L ≥ 1).
- Total run: 1 (start→FETCH) + N*(18+L) + 1 (DONE), where N is the number of windows.
- pool_done = 1 outside POOL is ignored.
- pool_done on the same cycle pool_en first rises counts as L = 1. Its result is accepted.
- Last window: its out_wr_en cycle is immediately followed by the done pulse.
- No stall input. The memory must meet the fixed 1-cycle read latency.

## Structure
- Shared package `pool_pkg` holds:
  - DATA_W, WIN and the derived WIN_AREA = WIN*WIN
  - the state enum
  - a function computing the window sample address
- Sub-module `window_addr_gen` produces mem_rd_addr and the slot index from wx, wy and k, and owns the wx/wy/k counters.
- The top level holds the FSM, the window register file and the handshake.

## Test plan
- Ramp map, mem[i] = i, 8×8 image, pool model with L = 1 → out[0..3] = 27, 31, 59, 63. done fires exactly once, 1 + 4*19 + 1 cycles after start.
- Map of all −5 (22'h3FFFFB), L = 1 → all four outputs are 22'h3FFFFB. win_data slots all equal 22'h3FFFFB in POOL.
- Ramp map, pool model with L = 5 → pool_en is held 5 cycles per window. Outputs are as in the first scenario. Total cycles are 1 + 4*23 + 1.
- start pulsed again mid-FETCH of window 1 → ignored. Exactly 4 writes and one done.
- rst_n low during POOL of window 2 → next cycle busy = 0, pool_en = 0, state IDLE. A subsequent start re-runs from window 0 with correct outputs.
- Address check on the ramp map: window 1 issues reads 4, 5, 6, 7, 12, …, 31, in that order, one per cycle with no gaps.
